// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 control unit: fetch/decode/execute sequencing with Moore-decoded
// datapath controls and a mem_ready stall on every memory-access state.
module lc3_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        sr2mux,
  output logic        sr1mux,
  output logic        drmux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        r_w,
  output logic        halted,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH0 = 5'd1,
    S_FETCH1 = 5'd2,
    S_FETCH2 = 5'd3,
    S_DECODE = 5'd4,
    S_ALU    = 5'd5,
    S_BR     = 5'd6,
    S_JMP    = 5'd7,
    S_JSR0   = 5'd8,
    S_JSR1   = 5'd9,
    S_LEA    = 5'd10,
    S_ADDR   = 5'd11,
    S_LD1    = 5'd12,
    S_LD2    = 5'd13,
    S_ST0    = 5'd14,
    S_ST1    = 5'd15,
    S_HALT   = 5'd16
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] opcode;
  logic       ben;
  logic       unused_ir_bits;

  assign opcode         = ir[15:12];
  assign ben            = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign unused_ir_bits = ^{ir[8:6], ir[4:0]};
  assign state          = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_pc       = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = 2'd0;
    addr1mux    = 1'b0;
    addr2mux    = 2'd0;
    sr2mux      = 1'b0;
    sr1mux      = 1'b0;
    drmux       = 1'b0;
    aluk        = 2'd0;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    halted      = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH0;
      S_FETCH0: begin
        gate_pc    = 1'b1;
        ld_mar     = 1'b1;
        ld_pc      = 1'b1;
        state_next = S_FETCH1;
      end
      S_FETCH1: begin
        mio_en     = 1'b1;
        ld_mdr     = mem_ready;
        state_next = mem_ready ? S_FETCH2 : S_FETCH1;
      end
      S_FETCH2: begin
        gate_mdr   = 1'b1;
        ld_ir      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001:          state_next = S_ALU;
          4'b0000:                            state_next = S_BR;
          4'b1100:                            state_next = S_JMP;
          4'b0100:                            state_next = S_JSR0;
          4'b1110:                            state_next = S_LEA;
          4'b0010, 4'b0011, 4'b0110, 4'b0111: state_next = S_ADDR;
          default:                            state_next = S_HALT;
        endcase
      end
      S_ALU: begin
        sr1mux     = 1'b1;
        sr2mux     = ir[5];
        aluk       = (opcode == 4'b0101) ? 2'd1 : (opcode == 4'b1001) ? 2'd2 : 2'd0;
        gate_alu   = 1'b1;
        ld_reg     = 1'b1;
        ld_cc      = 1'b1;
        state_next = S_FETCH0;
      end
      S_BR: begin
        if (ben) begin
          ld_pc    = 1'b1;
          pcmux    = 2'd2;
          addr2mux = 2'd2;
        end
        state_next = S_FETCH0;
      end
      S_JMP: begin
        sr1mux     = 1'b1;
        addr1mux   = 1'b1;
        pcmux      = 2'd2;
        ld_pc      = 1'b1;
        state_next = S_FETCH0;
      end
      S_JSR0: begin
        gate_pc    = 1'b1;
        drmux      = 1'b1;
        ld_reg     = 1'b1;
        state_next = S_JSR1;
      end
      S_JSR1: begin
        ld_pc = 1'b1;
        pcmux = 2'd2;
        // ir[11] selects PC-relative JSR over register-based JSRR
        if (ir[11]) begin
          addr2mux = 2'd3;
        end else begin
          addr1mux = 1'b1;
          sr1mux   = 1'b1;
        end
        state_next = S_FETCH0;
      end
      S_LEA: begin
        addr2mux    = 2'd2;
        gate_marmux = 1'b1;
        ld_reg      = 1'b1;
        state_next  = S_FETCH0;
      end
      S_ADDR: begin
        // ir[14] distinguishes base+offset6 (LDR/STR) from PC+offset9 (LD/ST)
        if (ir[14]) begin
          addr1mux = 1'b1;
          sr1mux   = 1'b1;
          addr2mux = 2'd1;
        end else begin
          addr2mux = 2'd2;
        end
        gate_marmux = 1'b1;
        ld_mar      = 1'b1;
        state_next  = ir[12] ? S_ST0 : S_LD1;
      end
      S_LD1: begin
        mio_en     = 1'b1;
        ld_mdr     = mem_ready;
        state_next = mem_ready ? S_LD2 : S_LD1;
      end
      S_LD2: begin
        gate_mdr   = 1'b1;
        ld_reg     = 1'b1;
        ld_cc      = 1'b1;
        state_next = S_FETCH0;
      end
      S_ST0: begin
        aluk       = 2'd3;
        gate_alu   = 1'b1;
        ld_mdr     = 1'b1;
        state_next = S_ST1;
      end
      S_ST1: begin
        mio_en     = 1'b1;
        r_w        = 1'b1;
        state_next = mem_ready ? S_FETCH0 : S_ST1;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Multi-cycle control unit for the LC-3 datapath. It sequences fetch, decode and execute, and drives every load enable, bus gate and mux select, including the ADDR2MUX choice among the offset sign-extenders and the SR2MUX choice of the imm5 extender. It uses a ready handshake to stall on memory. The unit sits between the instruction register/condition-code registers and the shared bus datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ir  in  16  current IR contents (registered externally, loaded by ld_ir)
- n, z, p  in  1 each  current condition codes
- mem_ready  in  1  memory completes the current access this cycle
- ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc  out  1 each  register load enables
- gate_pc, gate_mdr, gate_alu, gate_marmux  out  1 each  bus drivers (at most one high)
- pcmux  out  2  0=PC+1, 1=bus, 2=address adder
- addr1mux  out  1  0=PC, 1=BaseR (SR1 output)
- addr2mux  out  2  0=zero, 1=SEXT(IR[5:0]), 2=SEXT(IR[8:0]), 3=SEXT(IR[10:0])
- sr2mux  out  1  0=register SR2, 1=SEXT(IR[4:0])
- sr1mux  out  1  0=IR[11:9], 1=IR[8:6]
- drmux  out  1  0=IR[11:9], 1=R7
- aluk  out  2  0=ADD, 1=AND, 2=NOT, 3=PASSA
- mio_en, r_w  out  1 each  memory enable; r_w 1=write
- halted  out  1  unsupported opcode trapped
- state  out  5  current state code (debug)

## Operation
- Moore decode from state. Outputs not listed for a state are 0. The only exception is ld_mdr, which equals mem_ready in read states.
- States and actions:
  - IDLE(0): all outputs 0; next FETCH0.
  - FETCH0(1): gate_pc, ld_mar, pcmux=0, ld_pc.
  - FETCH1(2): mio_en, r_w=0, ld_mdr=mem_ready; stays until mem_ready.
  - FETCH2(3): gate_mdr, ld_ir.
  - DECODE(4): no outputs; branches on ir[15:12].
  - ALU(5): ADD 0001, AND 0101, NOT 1001. sr1mux=1, sr2mux=ir[5], aluk=0/1/2, gate_alu, ld_reg, ld_cc, drmux=0.
  - BR(6): 0000. BEN=(ir[11]&n)|(ir[10]&z)|(ir[9]&p). If BEN: ld_pc, pcmux=2, addr1mux=0, addr2mux=2.
  - JMP(7): 1100. sr1mux=1, addr1mux=1, addr2mux=0, pcmux=2, ld_pc.
  - JSR0(8): 0100. gate_pc, drmux=1, ld_reg.
  - JSR1(9): ld_pc, pcmux=2. If ir[11]: addr1mux=0, addr2mux=3. Else: addr1mux=1, sr1mux=1, addr2mux=0.
  - LEA(10): 1110. addr1mux=0, addr2mux=2, gate_marmux, ld_reg, drmux=0. No CC update.
  - ADDR(11): LD 0010, ST 0011 use addr1mux=0, addr2mux=2. LDR 0110, STR 0111 use addr1mux=1, sr1mux=1, addr2mux=1. All drive gate_marmux, ld_mar. Loads go to LD1; stores go to ST0.
  - LD1(12): mio_en, r_w=0, ld_mdr=mem_ready; holds until mem_ready.
  - LD2(13): gate_mdr, ld_reg, ld_cc, drmux=0.
  - ST0(14): sr1mux=0, aluk=3, gate_alu, ld_mdr.
  - ST1(15): mio_en, r_w=1; holds until mem_ready.
  - HALT(16): halted=1, all else 0; absorbing until reset.
- ALU, BR, JMP, JSR1, LEA and LD2 return to FETCH0. ST1 returns to FETCH0 on mem_ready.
- Opcodes 1000, 1010, 1011, 1101 and 1111 go from DECODE to HALT.
- JSRR with BaseR=R7: R7 is written in JSR0 first, so the jump target is the return address. This is a documented limitation.

## Timing
- Reset: state=IDLE asynchronously. All outputs are 0 (halted=0, state=0) while rst_n is low and in the first cycle after release.
- Reset mid-instruction aborts immediately. No partial writes occur after the reset edge.
- Cycles per instruction with zero-wait memory (mem_ready constantly 1):
  - ADD/AND/NOT/BR/JMP/LEA: 5
  - JSR/JSRR: 6
  - LD/LDR and ST/STR: 7
  - Each memory state adds one cycle per cycle of mem_ready low.
- mem_ready is sampled only in FETCH1, LD1 and ST1. In all other states it is ignored.
- A not-taken BR still occupies the BR state for one cycle.

## Test plan
- Reset, then ir=0x1261 (ADD R1,R1,#1), mem_ready=1 -> states 0,1,2,3,4,5,1. In state 5: sr2mux=1, aluk=0, ld_reg=ld_cc=1.
- ir=0x0402 (BRz) with z=1 -> BR asserts ld_pc, pcmux=2, addr2mux=2. With z=0 -> ld_pc=0 and next state FETCH0.
- ir=0x6042 (LDR R0,R1,#2), mem_ready low for 3 cycles in LD1 -> LD1 held 4 cycles. ld_mdr pulses only in the ready cycle. LD2 asserts gate_mdr, ld_cc.
- ir=0x7042 (STR) -> ST0 aluk=3, sr1mux=0. ST1 has r_w=1 and mio_en=1 until mem_ready.
- ir=0x4800 (JSR) -> JSR0 drmux=1, gate_pc. JSR1 addr2mux=3. Total 6 cycles.
- ir=0xF025 (TRAP) -> HALT, halted=1 held. rst_n pulse low -> state=0, halted=0 asynchronously.
